// File: rtl/vga_sync_pkg.sv
// vga_sync_pkg: shared timing constants and types for the VGA sync generator.
//   DEF_*    default 640x480@60 timing (pixels / lines)
//   H_TOTAL  pixels per line including blanking (800)
//   V_TOTAL  lines per frame including blanking (525)
//   count_t  10-bit unsigned pixel/line count
//   in_range inclusive range test used by the sync decode
// Optional feature macro: VGA_SYNC_TICK_DIV_EN (consumed by vga_pixel_tick).
package vga_sync_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] count_t;

  function automatic logic in_range(input count_t val, input count_t lo, input count_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if: bundle of the video timing outputs of vga_sync.
//   hsync, vsync  active-low sync pulses
//   video_on      visible-area flag
//   p_tick        pixel enable
//   x, y          current pixel / line count
// master: the timing generator side; slave: the pixel/display consumer side.
// Optional feature macro: VGA_SYNC_TICK_DIV_EN (affects p_tick rate only).
interface vga_sync_if;
  import vga_sync_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  count_t x;
  count_t y;

  modport master (output hsync, output vsync, output video_on,
                  output p_tick, output x, output y);
  modport slave  (input hsync, input vsync, input video_on,
                  input p_tick, input x, input y);

endinterface

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: pixel enable generator for vga_sync.
//   clk     system clock
//   reset   asynchronous active-low reset
//   p_tick  pixel enable (0 while in reset)
// Macro VGA_SYNC_TICK_DIV_EN defined: p_tick = toggle flop, high on every
// second clk, first high right after the first clk edge out of reset.
// Macro undefined: clk is the pixel clock, p_tick is simply high outside reset.
module vga_pixel_tick (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

`ifdef VGA_SYNC_TICK_DIV_EN
  logic toggle_q;
  logic toggle_d;

  always_comb begin
    toggle_d = ~toggle_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) toggle_q <= 1'b0;
    else        toggle_q <= toggle_d;
  end

  assign p_tick = toggle_q;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign p_tick     = reset;
`endif

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA horizontal/vertical timing generator.
//   clk       system clock
//   reset     asynchronous active-low reset
//   hsync     horizontal sync, active-low, registered
//   vsync     vertical sync, active-low, registered
//   video_on  high while (x, y) is inside the visible area
//   p_tick    pixel enable; counters advance only when it is high
//   x, y      current pixel and line count
// Macro VGA_SYNC_TICK_DIV_EN selects a clk/2 pixel enable (see vga_pixel_tick);
// without it every clk is a pixel.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam count_t H_MAX    = count_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam count_t V_MAX    = count_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam count_t H_VIS    = count_t'(H_DISPLAY);
  localparam count_t V_VIS    = count_t'(V_DISPLAY);
  localparam count_t HS_START = count_t'(H_DISPLAY + H_FRONT);
  localparam count_t HS_END   = count_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam count_t VS_START = count_t'(V_DISPLAY + V_FRONT);
  localparam count_t VS_END   = count_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  count_t h_q, h_d;
  count_t v_q, v_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   tick;

  vga_pixel_tick u_pixel_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + count_t'(1);
      end else begin
        h_d = h_q + count_t'(1);
      end
    end
    // Decoding the next counts lets the registered syncs line up with x/y.
    hsync_d = ~in_range(h_d, HS_START, HS_END);
    vsync_d = ~in_range(v_d, VS_START, VS_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_q < H_VIS) && (v_q < V_VIS);
  assign p_tick   = tick;
  assign x        = h_q;
  assign y        = v_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of vga_sync. A default-timing instance covers
// the horizontal timing; a shrunken-timing instance covers vertical timing,
// frame wrap and mid-frame reset within a short run. Works with or without
// VGA_SYNC_TICK_DIV_EN (DIV = clk edges per pixel).
module tb_vga_sync;
  import vga_sync_pkg::*;

`ifdef VGA_SYNC_TICK_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  logic reset_d;
  logic reset_s;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ed     = 0;
  int   lo_cnt;
  int   tk_cnt;

  vga_sync_if bus_d ();
  vga_sync_if bus_s ();

  vga_sync u_dflt (
    .clk      (clk),
    .reset    (reset_d),
    .hsync    (bus_d.hsync),
    .vsync    (bus_d.vsync),
    .video_on (bus_d.video_on),
    .p_tick   (bus_d.p_tick),
    .x        (bus_d.x),
    .y        (bus_d.y)
  );

  // H total 15 (sync at x=10..12), V total 9 (sync at y=6..7), frame 135 ticks.
  vga_sync #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (2), .V_SYNC (2), .V_BACK (1)
  ) u_small (
    .clk      (clk),
    .reset    (reset_s),
    .hsync    (bus_s.hsync),
    .vsync    (bus_s.vsync),
    .video_on (bus_s.video_on),
    .p_tick   (bus_s.p_tick),
    .x        (bus_s.x),
    .y        (bus_s.y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic goto(input int k);
    while (ed < k) step();
  endtask

  initial begin
    reset_d = 1'b0;
    reset_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x",        32'(bus_d.x), 0);
    check("rst_y",        32'(bus_d.y), 0);
    check("rst_hsync",    32'(bus_d.hsync), 1);
    check("rst_vsync",    32'(bus_d.vsync), 1);
    check("rst_video_on", 32'(bus_d.video_on), 1);
    check("rst_p_tick",   32'(bus_d.p_tick), 0);
    check("s_rst_vsync",  32'(bus_s.vsync), 1);
    check("s_rst_p_tick", 32'(bus_s.p_tick), 0);

    // default instance: horizontal timing
    @(negedge clk);
    reset_d = 1'b1;
    ed = 0;
    goto(1);
    check("tick_e1", 32'(bus_d.p_tick), 1);
    check("x_e1",    32'(bus_d.x), 1 / DIV);
    goto(2);
    check("tick_e2", 32'(bus_d.p_tick), (DIV == 2) ? 0 : 1);
    check("x_e2",    32'(bus_d.x), 2 / DIV);
    goto(639 * DIV);
    check("x_639",     32'(bus_d.x), 639);
    check("vid_x639",  32'(bus_d.video_on), 1);
    goto(640 * DIV);
    check("x_640",     32'(bus_d.x), 640);
    check("vid_x640",  32'(bus_d.video_on), 0);
    goto(655 * DIV);
    check("hs_x655",   32'(bus_d.hsync), 1);
    goto(656 * DIV);
    check("x_656",     32'(bus_d.x), 656);
    check("hs_x656",   32'(bus_d.hsync), 0);
    goto(751 * DIV);
    check("hs_x751",   32'(bus_d.hsync), 0);
    goto(752 * DIV);
    check("x_752",     32'(bus_d.x), 752);
    check("hs_x752",   32'(bus_d.hsync), 1);
    goto(799 * DIV);
    check("x_799",     32'(bus_d.x), 799);
    check("y_line0",   32'(bus_d.y), 0);
    goto(800 * DIV);
    check("x_wrap",    32'(bus_d.x), 0);
    check("y_line1",   32'(bus_d.y), 1);
    check("vid_x0",    32'(bus_d.video_on), 1);

    lo_cnt = 0;
    tk_cnt = 0;
    repeat (800 * DIV) begin
      step();
      if (bus_d.hsync == 1'b0) lo_cnt++;
      if (bus_d.p_tick == 1'b1) tk_cnt++;
    end
    check("hs_low_clk",     lo_cnt, 96 * DIV);
    check("ticks_per_line", tk_cnt, 800);
    check("y_line2",        32'(bus_d.y), 2);

    goto((2 * 800 + 300) * DIV);
    check("x_300", 32'(bus_d.x), 300);
    reset_d = 1'b0;
    #1;
    check("mid_rst_x",     32'(bus_d.x), 0);
    check("mid_rst_y",     32'(bus_d.y), 0);
    check("mid_rst_tick",  32'(bus_d.p_tick), 0);
    check("mid_rst_vid",   32'(bus_d.video_on), 1);
    check("mid_rst_hsync", 32'(bus_d.hsync), 1);

    // small instance: vertical timing, frame wrap, mid-frame reset
    @(negedge clk);
    reset_s = 1'b1;
    ed = 0;
    goto(45 * DIV);
    check("s_y3",       32'(bus_s.y), 3);
    check("s_vid_y3x0", 32'(bus_s.video_on), 1);
    goto(59 * DIV);
    check("s_vid_x14",  32'(bus_s.video_on), 0);
    goto(60 * DIV);
    check("s_y4",       32'(bus_s.y), 4);
    check("s_vid_y4x0", 32'(bus_s.video_on), 0);
    goto(89 * DIV);
    check("s_vs_y5",    32'(bus_s.vsync), 1);
    goto(90 * DIV);
    check("s_y6",       32'(bus_s.y), 6);
    check("s_vs_y6",    32'(bus_s.vsync), 0);
    goto(119 * DIV);
    check("s_vs_y7",    32'(bus_s.vsync), 0);
    goto(120 * DIV);
    check("s_y8",       32'(bus_s.y), 8);
    check("s_vs_y8",    32'(bus_s.vsync), 1);
    goto(134 * DIV);
    check("s_x_last",   32'(bus_s.x), 14);
    check("s_y_last",   32'(bus_s.y), 8);
    goto(135 * DIV);
    check("s_x_wrap",   32'(bus_s.x), 0);
    check("s_y_wrap",   32'(bus_s.y), 0);

    lo_cnt = 0;
    repeat (135 * DIV) begin
      step();
      if (bus_s.vsync == 1'b0) lo_cnt++;
    end
    check("s_vs_low_clk", lo_cnt, 30 * DIV);

    goto(371 * DIV);
    check("s_x11",    32'(bus_s.x), 11);
    check("s_hs_x11", 32'(bus_s.hsync), 0);
    check("s_vs_y6b", 32'(bus_s.vsync), 0);
    reset_s = 1'b0;
    #1;
    check("s_mid_rst_hsync", 32'(bus_s.hsync), 1);
    check("s_mid_rst_vsync", 32'(bus_s.vsync), 1);
    check("s_mid_rst_x",     32'(bus_s.x), 0);
    check("s_mid_rst_y",     32'(bus_s.y), 0);
    check("s_mid_rst_tick",  32'(bus_s.p_tick), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
